// File: rtl/wrr_arb.sv
// -----------------------------------------------------------------------------
// wrr_arb : weighted round-robin arbiter with a registered valid/ready grant.
//
// REQCNT requesters compete for one shared resource. Each requester carries a
// weight, which is the number of back-to-back accepted grants (burst credits)
// it may take before the round-robin pointer moves on. The grant is held stable
// until the consumer accepts it. All outputs come straight from registers.
//
// Optional feature (compile-time macro WRR_MAXWAIT_EN):
//   When defined, each requester has a saturating 32-bit wait counter, and
//   max_wait_o reports the running maximum of those counters since reset.
//   When undefined, the port, the counters and the related logic are absent.
// -----------------------------------------------------------------------------
module wrr_arb #(
  parameter int REQCNT   = 20,
  parameter int WEIGHT_W = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [REQCNT-1:0]            req_i,
  input  logic [REQCNT*WEIGHT_W-1:0]   weight_i,
  input  logic                         gnt_ready_i,
  output logic                         gnt_val_o,
  output logic [$clog2(REQCNT)-1:0]    gnt_num_o,
  output logic [REQCNT-1:0]            gnt_onehot_o
`ifdef WRR_MAXWAIT_EN
  ,
  output logic [31:0]                  max_wait_o
`endif
);

  localparam int NUM_W = $clog2(REQCNT);

  // FSM encoding kept as plain constants so older tools and netlists match.
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  localparam logic [NUM_W-1:0] LAST_IDX = NUM_W'(REQCNT - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]          state_q,  state_d;
  logic [NUM_W-1:0]    gnt_num_q, gnt_num_d;
  logic [REQCNT-1:0]   onehot_q,  onehot_d;
  logic [WEIGHT_W-1:0] credit_q,  credit_d;
  logic [NUM_W-1:0]    last_q,    last_d;

  // Round-robin search results
  logic [NUM_W-1:0]    scan_base;
  logic                scan_hit;
  logic [NUM_W-1:0]    scan_sel;

  logic                accept;

  // Effective weight of requester idx: a programmed 0 behaves as 1 so that a
  // granted requester always consumes at least one grant.
  function automatic logic [WEIGHT_W-1:0] eff_weight(
    input logic [REQCNT*WEIGHT_W-1:0] w,
    input logic [NUM_W-1:0]           idx
  );
    logic [WEIGHT_W-1:0] raw;
    raw = w[idx*WEIGHT_W +: WEIGHT_W];
    return (raw == '0) ? WEIGHT_W'(1) : raw;
  endfunction

  // The consumer takes the current grant this cycle.
  assign accept = (state_q == S_GRANT) && gnt_ready_i;

  // Circular search for the first pending request after scan_base.
  // In IDLE the pointer is the last served requester; while granting, a
  // rescan starts right after the requester currently holding the grant,
  // which is exactly where the pointer will land once the grant is released.
  always_comb begin
    int idx;
    // NOTE: every variable assigned in a combinational block gets a default
    // first, otherwise paths that skip the assignment infer a latch.
    idx       = 0;
    scan_hit  = 1'b0;
    scan_sel  = '0;
    scan_base = (state_q == S_GRANT) ? gnt_num_q : last_q;
    for (int k = 0; k < REQCNT; k++) begin
      idx = int'(scan_base) + 1 + k;
      if (idx >= REQCNT) begin
        idx = idx - REQCNT;
      end
      if (!scan_hit && req_i[idx]) begin
        scan_hit = 1'b1;
        scan_sel = NUM_W'(idx);
      end
    end
  end

  // Next-state logic for the grant FSM, burst credits and round-robin pointer.
  always_comb begin
    state_d   = state_q;
    gnt_num_d = gnt_num_q;
    credit_d  = credit_q;
    last_d    = last_q;

    case (state_q)
      S_IDLE: begin
        if (scan_hit) begin
          state_d   = S_GRANT;
          gnt_num_d = scan_sel;
          credit_d  = eff_weight(weight_i, scan_sel);
        end
      end

      S_GRANT: begin
        // Without an accept the grant is frozen and req_i is ignored.
        if (accept) begin
          if ((credit_q > WEIGHT_W'(1)) && req_i[gnt_num_q]) begin
            // Burst continues on the same requester, no bubble.
            credit_d = credit_q - WEIGHT_W'(1);
          end else begin
            // Burst over: move the pointer and hand over immediately if
            // anybody is waiting. The current holder wins again only when
            // it is the sole requester, since the scan reaches it last.
            last_d = gnt_num_q;
            if (scan_hit) begin
              gnt_num_d = scan_sel;
              credit_d  = eff_weight(weight_i, scan_sel);
            end else begin
              state_d  = S_IDLE;
              credit_d = '0;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // One-hot grant is registered alongside the index so both change together
  // and the one-hot is all-zero whenever no grant is valid.
  always_comb begin
    onehot_d = '0;
    if (state_d == S_GRANT) begin
      onehot_d[gnt_num_d] = 1'b1;
    end
  end

  // Grant FSM registers. An asynchronous reset drops any pending grant
  // immediately; the pointer restarts so the first scan begins at 0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      gnt_num_q <= '0;
      onehot_q  <= '0;
      credit_q  <= '0;
      last_q    <= LAST_IDX;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state_q   <= state_d;
      gnt_num_q <= gnt_num_d;
      onehot_q  <= onehot_d;
      credit_q  <= credit_d;
      last_q    <= last_d;
    end
  end

  assign gnt_val_o    = (state_q == S_GRANT);
  assign gnt_num_o    = gnt_num_q;
  assign gnt_onehot_o = onehot_q;

`ifdef WRR_MAXWAIT_EN
  // ---------------------------------------------------------------------------
  // Starvation statistics
  // ---------------------------------------------------------------------------
  logic [31:0] wait_q [REQCNT];
  logic [31:0] cur_max;
  logic [31:0] max_q;

  // Per-requester wait counters: count cycles spent requesting without being
  // accepted, clear on accept or when the request is withdrawn, saturate.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: this counter array is small and its reset value is observable
      // through max_wait_o, so every entry is reset explicitly.
      for (int i = 0; i < REQCNT; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REQCNT; i++) begin
        if (req_i[i] && !(accept && onehot_q[i])) begin
          if (wait_q[i] != '1) begin
            wait_q[i] <= wait_q[i] + 32'd1;
          end
        end else begin
          wait_q[i] <= '0;
        end
      end
    end
  end

  // Largest counter value this cycle.
  always_comb begin
    cur_max = '0;
    for (int i = 0; i < REQCNT; i++) begin
      if (wait_q[i] > cur_max) begin
        cur_max = wait_q[i];
      end
    end
  end

  // Running maximum since reset; only reset lowers it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      max_q <= '0;
    end else if (cur_max > max_q) begin
      max_q <= cur_max;
    end
  end

  assign max_wait_o = max_q;
`endif

endmodule

// File: tb/tb_wrr_arb.sv
// -----------------------------------------------------------------------------
// tb_wrr_arb : directed self-checking bench for wrr_arb (REQCNT=4, WEIGHT_W=4).
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Compile with +define+WRR_MAXWAIT_EN to also exercise max_wait_o.
// -----------------------------------------------------------------------------
module tb_wrr_arb;

  localparam int REQCNT   = 4;
  localparam int WEIGHT_W = 4;

  logic                       clk_i;
  logic                       rst_n_i;
  logic [REQCNT-1:0]          req_i;
  logic [REQCNT*WEIGHT_W-1:0] weight_i;
  logic                       gnt_ready_i;
  logic                       gnt_val_o;
  logic [1:0]                 gnt_num_o;
  logic [REQCNT-1:0]          gnt_onehot_o;
`ifdef WRR_MAXWAIT_EN
  logic [31:0]                max_wait_o;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected grant sequence for weights {w3,w2,w1,w0} = {1,3,2,1}.
  int seq_w1231 [10] = '{0, 1, 1, 2, 2, 2, 3, 0, 1, 1};
  // Burst resume after the stall: two remaining credits on 2, then 3.
  int seq_resume [3] = '{2, 2, 3};
  // Drop scenario: 1 kept, then 2 (w=0 -> one grant), 0, 2.
  int seq_drop [4]   = '{1, 2, 0, 2};

  wrr_arb #(
    .REQCNT   (REQCNT),
    .WEIGHT_W (WEIGHT_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .req_i        (req_i),
    .weight_i     (weight_i),
    .gnt_ready_i  (gnt_ready_i),
    .gnt_val_o    (gnt_val_o),
    .gnt_num_o    (gnt_num_o),
    .gnt_onehot_o (gnt_onehot_o)
`ifdef WRR_MAXWAIT_EN
    ,
    .max_wait_o   (max_wait_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_n_i     = 1'b0;
    req_i       = '0;
    gnt_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
    do_reset();
    tests_run++;
    if ({gnt_val_o, gnt_num_o, gnt_onehot_o} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got val=%b num=%0d oh=%b, want val=0 num=0 oh=0000",
               gnt_val_o, gnt_num_o, gnt_onehot_o);
    end
`ifdef WRR_MAXWAIT_EN
    tests_run++;
    if (max_wait_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_max_wait: got %0d, want 0", max_wait_o);
    end
`endif
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    do_reset();
    weight_i    = {4'd1, 4'd1, 4'd1, 4'd1};
    req_i       = 4'b1111;
    gnt_ready_i = 1'b1;
    #1;
    tests_run++;
    if (gnt_val_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_latency: val=%b before first edge, want 0", gnt_val_o);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      exp_oh = 4'b0001 << (i % 4);
      tests_run++;
      if (gnt_val_o !== 1'b1 || gnt_num_o !== 2'(i % 4) || gnt_onehot_o !== exp_oh) begin
        tests_failed++;
        $display("FAIL rr_seq[%0d]: got val=%b num=%0d oh=%b, want val=1 num=%0d oh=%b",
                 i, gnt_val_o, gnt_num_o, gnt_onehot_o, i % 4, exp_oh);
      end
    end
  endtask

  task automatic test_weighted();
    do_reset();
    weight_i    = {4'd1, 4'd3, 4'd2, 4'd1};
    req_i       = 4'b1111;
    gnt_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      tests_run++;
      if (gnt_val_o !== 1'b1 || gnt_num_o !== 2'(seq_w1231[i])) begin
        tests_failed++;
        $display("FAIL wrr_seq[%0d]: got val=%b num=%0d, want val=1 num=%0d",
                 i, gnt_val_o, gnt_num_o, seq_w1231[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    weight_i    = {4'd1, 4'd3, 4'd2, 4'd1};
    req_i       = 4'b1111;
    gnt_ready_i = 1'b1;
    repeat (4) step();
    tests_run++;
    if (gnt_num_o !== 2'd2 || gnt_val_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_setup: got val=%b num=%0d, want val=1 num=2", gnt_val_o, gnt_num_o);
    end
    // Stall and wiggle req_i: the grant must not move.
    gnt_ready_i = 1'b0;
    req_i       = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (gnt_val_o !== 1'b1 || gnt_num_o !== 2'd2 || gnt_onehot_o !== 4'b0100) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got val=%b num=%0d oh=%b, want val=1 num=2 oh=0100",
                 i, gnt_val_o, gnt_num_o, gnt_onehot_o);
      end
    end
    req_i       = 4'b1111;
    gnt_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (gnt_val_o !== 1'b1 || gnt_num_o !== 2'(seq_resume[i])) begin
        tests_failed++;
        $display("FAIL stall_resume[%0d]: got val=%b num=%0d, want val=1 num=%0d",
                 i, gnt_val_o, gnt_num_o, seq_resume[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    weight_i    = {4'd2, 4'd0, 4'd0, 4'd0};
    req_i       = 4'b1000;
    gnt_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      tests_run++;
      if (gnt_val_o !== 1'b1 || gnt_num_o !== 2'd3 || gnt_onehot_o !== 4'b1000) begin
        tests_failed++;
        $display("FAIL sole_b2b[%0d]: got val=%b num=%0d oh=%b, want val=1 num=3 oh=1000",
                 i, gnt_val_o, gnt_num_o, gnt_onehot_o);
      end
    end
    req_i = 4'b0000;
    step();
    tests_run++;
    if (gnt_val_o !== 1'b0 || gnt_onehot_o !== 4'b0000) begin
      tests_failed++;
      $display("FAIL sole_release: got val=%b oh=%b, want val=0 oh=0000", gnt_val_o, gnt_onehot_o);
    end
    // Still idle one cycle later with no requests.
    step();
    tests_run++;
    if (gnt_val_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL sole_idle: got val=%b, want 0", gnt_val_o);
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    weight_i    = {4'd1, 4'd0, 4'd3, 4'd1};
    req_i       = 4'b0010;
    gnt_ready_i = 1'b0;
    step();
    tests_run++;
    if (gnt_val_o !== 1'b1 || gnt_num_o !== 2'd1) begin
      tests_failed++;
      $display("FAIL drop_first: got val=%b num=%0d, want val=1 num=1", gnt_val_o, gnt_num_o);
    end
    gnt_ready_i = 1'b1;
    req_i       = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) req_i = 4'b0101;
      tests_run++;
      if (gnt_val_o !== 1'b1 || gnt_num_o !== 2'(seq_drop[i])) begin
        tests_failed++;
        $display("FAIL drop_seq[%0d]: got val=%b num=%0d, want val=1 num=%0d",
                 i, gnt_val_o, gnt_num_o, seq_drop[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    weight_i    = {4'd3, 4'd3, 4'd3, 4'd3};
    req_i       = 4'b1111;
    gnt_ready_i = 1'b1;
    repeat (2) step();
    #2;
    rst_n_i = 1'b0;
    #1;
    tests_run++;
    if ({gnt_val_o, gnt_num_o, gnt_onehot_o} !== 7'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got val=%b num=%0d oh=%b, want val=0 num=0 oh=0000",
               gnt_val_o, gnt_num_o, gnt_onehot_o);
    end
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    step();
    tests_run++;
    if (gnt_val_o !== 1'b1 || gnt_num_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL post_reset_scan: got val=%b num=%0d, want val=1 num=0", gnt_val_o, gnt_num_o);
    end
  endtask

`ifdef WRR_MAXWAIT_EN
  task automatic test_max_wait();
    do_reset();
    weight_i    = {4'd1, 4'd1, 4'd1, 4'd1};
    req_i       = 4'b1111;
    gnt_ready_i = 1'b1;
    repeat (12) step();
    tests_run++;
    if (max_wait_o !== 32'd4) begin
      tests_failed++;
      $display("FAIL max_wait: got %0d, want 4", max_wait_o);
    end
  endtask
`endif

  initial begin
    rst_n_i     = 1'b0;
    req_i       = '0;
    gnt_ready_i = 1'b0;
    weight_i    = '0;
    test_reset();
    test_round_robin();
    test_weighted();
    test_back_pressure();
    test_back_to_back();
    test_req_drop();
    test_async_reset();
`ifdef WRR_MAXWAIT_EN
    test_max_wait();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 ns, want completion");
    $fatal(1, "watchdog");
  end

endmodule
